aes_job_launcher: RTL

Initiator-side sequencer for the HWPE peripheral configuration port of the AES accelerator. It drives the periph protocol as a master against the HWPE control slave, performing these steps in order:
- acquire a job context;
- write the job registers;
- trigger execution;
- wait for the end-of-job event;
- read back the status word.

It sits between a local controller (core-less test harness or DMA-style launcher) and the AES HWPE's `periph` slave port.

---
 rtl/aes_job_launcher.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/aes_job_launcher.sv
// Periph-bus master that runs one AES HWPE job: acquire a context, program the job
// registers, trigger, wait for the end-of-job event, then read back the status word.
module aes_job_launcher #(
  parameter int unsigned          ID_WIDTH      = 10,
  parameter logic [ID_WIDTH-1:0]  MASTER_ID     = '0,
  parameter int unsigned          N_JOB_REGS    = 8,
  parameter logic [31:0]          BASE_ADDR     = 32'h0,
  parameter logic [31:0]          TRIGGER_OFFS  = 32'h00,
  parameter logic [31:0]          ACQUIRE_OFFS  = 32'h04,
  parameter logic [31:0]          STATUS_OFFS   = 32'h0C,
  parameter logic [31:0]          JOB_OFFS      = 32'h40,
  parameter int unsigned          MAX_ACQ_RETRY = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [N_JOB_REGS-1:0][31:0]  job_regs_i,
  input  logic                         evt_i,
  output logic                         ready_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [7:0]                   job_id_o,
  output logic [31:0]                  status_o,
  output logic [3:0]                   state_o,
  output logic                         periph_req,
  output logic [31:0]                  periph_add,
  output logic                         periph_wen,
  output logic [3:0]                   periph_be,
  output logic [31:0]                  periph_data,
  output logic [ID_WIDTH-1:0]          periph_id,
  input  logic                         periph_gnt,
  input  logic [31:0]                  periph_r_data,
  input  logic                         periph_r_valid,
  input  logic [ID_WIDTH-1:0]          periph_r_id
);

  // Handshake: a request is held (req=1, fields frozen) until a cycle with gnt=1;
  // the single outstanding response completes on r_valid=1 with r_id=MASTER_ID.
  typedef enum logic [3:0] {
    IDLE, ACQ_REQ, ACQ_RSP, CFG_REQ, CFG_RSP, TRG_REQ, TRG_RSP, WAIT_EVT, STS_REQ, STS_RSP
  } state_t;

  localparam int unsigned IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam int unsigned RTY_W = $clog2(MAX_ACQ_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_JOB_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_ACQ_RETRY);
  localparam logic [31:0] ACQ_ADDR = BASE_ADDR + ACQUIRE_OFFS;
  localparam logic [31:0] TRG_ADDR = BASE_ADDR + TRIGGER_OFFS;
  localparam logic [31:0] STS_ADDR = BASE_ADDR + STATUS_OFFS;
  localparam logic [31:0] JOB_ADDR = BASE_ADDR + JOB_OFFS;

  state_t                        state;
  logic [N_JOB_REGS-1:0][31:0]   regs;
  logic [IDX_W-1:0]              idx;
  logic [RTY_W-1:0]              retry;
  logic                          evt_flag;
  logic                          rsp_ok;

  assign rsp_ok  = periph_r_valid && (periph_r_id == MASTER_ID);
  assign ready_o = (state == IDLE);
  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      regs        <= '0;
      idx         <= '0;
      retry       <= '0;
      evt_flag    <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      job_id_o    <= '0;
      status_o    <= '0;
      periph_req  <= 1'b0;
      periph_add  <= '0;
      periph_wen  <= 1'b0;
      periph_be   <= '0;
      periph_data <= '0;
      periph_id   <= '0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      // Sticky capture so an event racing the trigger handshake is not lost.
      if (state != IDLE && evt_i) evt_flag <= 1'b1;

      case (state)
        IDLE: begin
          if (start_i) begin
            regs        <= job_regs_i;
            retry       <= '0;
            idx         <= '0;
            evt_flag    <= 1'b0;
            state       <= ACQ_REQ;
            periph_req  <= 1'b1;
            periph_add  <= ACQ_ADDR;
            periph_wen  <= 1'b1;
            periph_be   <= 4'hF;
            periph_id   <= MASTER_ID;
            periph_data <= '0;
          end
        end
        ACQ_REQ, CFG_REQ, TRG_REQ, STS_REQ: begin
          if (periph_gnt) begin
            periph_req <= 1'b0;
            case (state)
              ACQ_REQ: state <= ACQ_RSP;
              CFG_REQ: state <= CFG_RSP;
              TRG_REQ: state <= TRG_RSP;
              default: state <= STS_RSP;
            endcase
          end
        end
        ACQ_RSP: begin
          if (rsp_ok) begin
            if (periph_r_data[31]) begin
              if (retry + 1'b1 == RTY_MAX) begin
                error_o <= 1'b1;
                state   <= IDLE;
              end else begin
                retry      <= retry + 1'b1;
                evt_flag   <= 1'b0;
                state      <= ACQ_REQ;
                periph_req <= 1'b1;
              end
            end else begin
              job_id_o    <= periph_r_data[7:0];
              idx         <= '0;
              state       <= CFG_REQ;
              periph_req  <= 1'b1;
              periph_add  <= JOB_ADDR;
              periph_wen  <= 1'b0;
              periph_data <= regs[0];
            end
          end
        end
        CFG_RSP: begin
          if (rsp_ok) begin
            periph_req <= 1'b1;
            if (idx == LAST_IDX) begin
              state       <= TRG_REQ;
              periph_add  <= TRG_ADDR;
              periph_data <= '0;
            end else begin
              idx         <= idx + 1'b1;
              state       <= CFG_REQ;
              periph_add  <= JOB_ADDR + ((32'(idx) + 32'd1) << 2);
              periph_data <= regs[idx + 1'b1];
            end
          end
        end
        TRG_RSP: begin
          if (rsp_ok) state <= WAIT_EVT;
        end
        WAIT_EVT: begin
          if (evt_flag || evt_i) begin
            state       <= STS_REQ;
            periph_req  <= 1'b1;
            periph_add  <= STS_ADDR;
            periph_wen  <= 1'b1;
            periph_data <= '0;
          end
        end
        STS_RSP: begin
          if (rsp_ok) begin
            status_o <= periph_r_data;
            done_o   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
